// File: rtl/tlul_rr_arbiter_m1_pkg.sv
// ============================================================================
// Module      : tlul_rr_arbiter_m1_pkg
// Description : TL-UL channel structures shared by the round-robin arbiter
//               and its surroundings (A channel + d_ready host->device,
//               D channel + a_ready device->host).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package tlul_rr_arbiter_m1_pkg;

    // Host-to-device: A-channel request plus the D-channel ready
    typedef struct packed {
        logic        a_valid;
        logic [2:0]  a_opcode;
        logic [2:0]  a_param;
        logic [1:0]  a_size;
        logic [7:0]  a_source;
        logic [31:0] a_address;
        logic [3:0]  a_mask;
        logic [31:0] a_data;
        logic        d_ready;
    } tl_h2d_t;

    // Device-to-host: D-channel response plus the A-channel ready
    typedef struct packed {
        logic        d_valid;
        logic [2:0]  d_opcode;
        logic [2:0]  d_param;
        logic [1:0]  d_size;
        logic [7:0]  d_source;
        logic        d_sink;
        logic [31:0] d_data;
        logic        d_error;
        logic        a_ready;
    } tl_d2h_t;

endpackage

`default_nettype wire

// File: rtl/tlul_rr_arbiter_m1.sv
// ============================================================================
// Module      : tlul_rr_arbiter_m1
// Description : M:1 TL-UL arbiter. Round-robin selection on the A channel
//               with a lock that freezes the winner until its handshake,
//               and an in-order tracking FIFO that steers each D-channel
//               response back to the host that issued the request.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tlul_rr_arbiter_m1
    import tlul_rr_arbiter_m1_pkg::*;
#(
    parameter int M              = 2,
    parameter int MaxOutstanding = 4,
    parameter int IdxW           = $clog2(M),
    parameter int CntW           = $clog2(MaxOutstanding + 1)
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  tl_h2d_t         tl_h_i [M],
    output tl_d2h_t         tl_h_o [M],
    output tl_h2d_t         tl_d_o,
    input  tl_d2h_t         tl_d_i,
    output logic [IdxW-1:0] grant_o,
    output logic [CntW-1:0] outstanding_o,
    output logic            unexpected_rsp_o
);

    localparam int c_PTR_W = $clog2(MaxOutstanding);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [IdxW-1:0]    r_rr_ptr;
    logic               r_lock;
    logic [IdxW-1:0]    r_lock_idx;
    logic [IdxW-1:0]    r_grant;
    logic [IdxW-1:0]    r_fifo [MaxOutstanding];
    logic [c_PTR_W-1:0] r_wptr;
    logic [c_PTR_W-1:0] r_rptr;
    logic [CntW-1:0]    r_count;

    // ------------------------------------------------------------------
    // Combinational signals
    // ------------------------------------------------------------------
    logic               w_any_valid;
    logic [IdxW-1:0]    w_rr_winner;
    logic [IdxW-1:0]    w_idx;
    logic [IdxW-1:0]    w_winner;
    logic [IdxW-1:0]    w_rr_next;
    logic [IdxW-1:0]    w_head;
    logic               w_full;
    logic               w_empty;
    logic               w_dev_a_valid;
    logic               w_push;
    logic               w_pop;

    // Round-robin search: scan from the far end so the candidate closest to
    // r_rr_ptr is the last one written and therefore wins.
    always_comb begin
        w_any_valid = 1'b0;
        w_rr_winner = r_rr_ptr;
        w_idx       = '0;
        for (int k = M - 1; k >= 0; k--) begin
            w_idx = IdxW'((int'(r_rr_ptr) + k) % M);
            if (tl_h_i[w_idx].a_valid) begin
                w_any_valid = 1'b1;
                w_rr_winner = w_idx;
            end
        end
    end

    assign w_full   = (r_count == CntW'(MaxOutstanding));
    assign w_empty  = (r_count == '0);
    assign w_winner = r_lock ? r_lock_idx : w_rr_winner;
    assign w_head   = r_fifo[r_rptr];

    // Reset also masks the combinational valids/readies so nothing is
    // offered or accepted while rst_i is held.
    assign w_dev_a_valid = tl_h_i[w_winner].a_valid & ~w_full & ~rst_i;
    assign w_push        = w_dev_a_valid & tl_d_i.a_ready;
    assign w_pop         = tl_d_i.d_valid & ~w_empty & tl_h_i[w_head].d_ready;
    assign w_rr_next     = (w_winner == IdxW'(M - 1)) ? '0 : w_winner + 1'b1;

    // With nobody requesting and no lock, the grant index holds its last value.
    assign grant_o          = (r_lock | w_any_valid) ? w_winner : r_grant;
    assign outstanding_o    = r_count;
    assign unexpected_rsp_o = tl_d_i.d_valid & w_empty & ~rst_i;

    // Device-side request: forward the winner, gate a_valid, pick d_ready.
    // An empty tracker sinks any stray response beat.
    always_comb begin
        tl_d_o         = tl_h_i[w_winner];
        tl_d_o.a_valid = w_dev_a_valid;
        tl_d_o.d_ready = w_empty ? 1'b1 : tl_h_i[w_head].d_ready;
    end

    // Host-side responses: D payload broadcast, d_valid only to the FIFO
    // head, a_ready only to the current winner.
    always_comb begin
        for (int i = 0; i < M; i++) begin
            tl_h_o[i]         = tl_d_i;
            tl_h_o[i].d_valid = tl_d_i.d_valid & ~w_empty & ~rst_i
                                & (w_head == IdxW'(i));
            tl_h_o[i].a_ready = tl_d_i.a_ready & ~w_full & ~rst_i
                                & (w_winner == IdxW'(i));
        end
    end

    // Arbitration state: round-robin pointer, lock flag/index, last grant.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_rr_ptr   <= '0;
            r_lock     <= 1'b0;
            r_lock_idx <= '0;
            r_grant    <= '0;
        end else begin
            r_grant <= grant_o;
            if (w_push) begin
                r_rr_ptr <= w_rr_next;
                r_lock   <= 1'b0;
            end else if (w_dev_a_valid) begin
                r_lock     <= 1'b1;
                r_lock_idx <= w_winner;
            end
        end
    end

    // Tracking FIFO: records the host of every accepted request in order.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < MaxOutstanding; i++) begin
                r_fifo[i] <= '0;
            end
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push) begin
                r_fifo[r_wptr] <= w_winner;
                r_wptr         <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
        end
    end

    // Outstanding counter: push and pop together leave it unchanged.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_count <= '0;
        end else begin
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

`default_nettype wire
